dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller downstream of the MEM stage. Consumes MEM's data-port request (address, write data, read/write strobes) plus the load/store funct3, and runs it as a req/ack transaction on an external data bus. Handles byte-lane steering, load sign/zero extension, misalignment detection and bus timeout. Stalls the core until the access completes and hands the extended load value to write-back.

## Interface
- `DATA_WIDTH`, 32: data width; equals `REG_DATA_WIDTH`.
- `ADDR_WIDTH`, 32: address width.
- `TIMEOUT`, 255: maximum cycles in BUS before a bus error is forced; range 1..255.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `data_re_i` in 1: load request from MEM.
- `data_we_i` in 1: store request from MEM.
- `data_addr_i` in ADDR_WIDTH: byte address (ALU result).
- `data_i` in DATA_WIDTH: store data (rs2).
- `funct3_i` in 3: access size/sign (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU).
- `stall_o` out 1: freeze PC and pipeline while high.
- `load_data_o` out DATA_WIDTH: extended load result to WB.
- `misalign_o` out 1: one-cycle fault pulse for a misaligned address or illegal funct3.
- `bus_err_o` out 1: one-cycle fault pulse for a bus error or timeout.
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: bus write.
- `bus_addr_o` out ADDR_WIDTH: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_be_o` out 4: byte enables.
- `bus_wdata_o` out DATA_WIDTH: lane-steered write data.
- `bus_ack_i` in 1: transfer done.
- `bus_rdata_i` in DATA_WIDTH: read word, valid with ack.
- `bus_err_i` in 1: error qualifier, sampled only with ack.

## Operation
- Request: `req = data_re_i | data_we_i`. If both are high, the access is a store.
- FSM states: IDLE, BUS, DONE.
  - IDLE, no req: stay in IDLE.
  - IDLE, req, legal: capture address, byte enables, write data, funct3 and we. Go to BUS.
  - IDLE, req, illegal (misaligned or bad funct3): go to DONE with `misalign_o` set. The bus is never touched.
  - BUS: `bus_req_o=1` and all bus outputs are held stable.
  - BUS, ack with `bus_err_i=0`: latch the extended read data (loads only). Go to DONE.
  - BUS, ack with `bus_err_i=1`: go to DONE with `bus_err_o` set. `load_data_o` is not updated.
  - BUS, timeout counter reaches TIMEOUT: go to DONE with `bus_err_o` set. `bus_req_o` drops.
  - DONE: go to IDLE unconditionally. The fault pulses are visible only in DONE.
- Alignment rules:
  - Word access needs `addr[1:0]==0`.
  - Half access needs `addr[0]==0`.
  - Byte access is always aligned.
  - funct3 3, 6, 7 are illegal. Funct3 4 or 5 on a store is illegal.
- Byte enables:
  - SB: `4'b0001<<addr[1:0]`, with the byte replicated on all four lanes.
  - SH: `addr[1] ? 4'b1100 : 4'b0011`, with the half replicated.
  - SW: `4'b1111`.
  - Loads: enables are computed the same way (informational).
- Load extension: select the byte/half at `addr[1:0]`. Sign-extend for funct3 0/1, zero-extend for 4/5, pass the word for 2.
- `stall_o = (IDLE & req) | BUS`. It is low in DONE, so the core advances at the end of DONE.
- An ack arriving outside BUS is ignored.

## Timing
- Reset (async, `rst=0`): state IDLE, timeout counter 0. All outputs 0: `stall_o`, `load_data_o`, `misalign_o`, `bus_err_o` and every `bus_*` output. Reset mid-transaction drops `bus_req_o` immediately and abandons the access.
- Minimum access, ack in the first BUS cycle: IDLE (stall) → BUS (stall) → DONE. A memory instruction takes 3 cycles.
- Each extra BUS cycle adds one cycle.
- A misaligned or illegal access takes 2 cycles (IDLE → DONE).
- `load_data_o` is registered. It updates on the edge leaving BUS on a good load ack and holds until the next good load.
- Timeout counter:
  - Cleared on entry to BUS and increments each BUS cycle without ack.
  - At count == TIMEOUT-1 with no ack, the next state is DONE with a bus error.
  - Ack and timeout on the same cycle: ack wins.
- Inputs are sampled only in IDLE. Input changes during BUS or DONE have no effect.

## Structure
- Shared constants belong in `riscv_def.v`:
  - funct3 codes `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`.
  - `REG_DATA_WIDTH`.
- State encodings stay local to the module.
- One combinational sub-module, `lsu_align`, holds the alignment check, byte-enable and write-lane steering, and load extraction/extension. The FSM, capture registers and timeout counter stay in `dmem_ctrl`.

## Test plan
- SW at addr 0x100 with data 0xDEADBEEF, ack on the first BUS cycle:
  - Bus sees addr 0x100, be 1111, wdata 0xDEADBEEF, we=1.
  - `stall_o` is high for 2 cycles, then low.
- LB at 0x103, bus word 0x80FF1234:
  - `load_data_o` = 0xFFFFFF80.
- LBU at the same address:
  - `load_data_o` = 0x00000080.
- LHU at 0x102, bus word 0xABCD0000:
  - `load_data_o` = 0x0000ABCD.
- SH at 0x101:
  - `bus_req_o` never rises.
  - `misalign_o` pulses 1 cycle.
  - `stall_o` is high exactly 1 cycle.
- LW with no ack, TIMEOUT=4:
  - `bus_req_o` is high for 4 cycles.
  - Then `bus_err_o` pulses and `load_data_o` is unchanged.
- `rst` asserted in the second BUS cycle:
  - All outputs go to 0 asynchronously.
  - After release, the state is IDLE and a new LW completes normally.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared load/store constants and the access-size decode used by the data-memory
// controller and its lane-steering helper.
package dmem_ctrl_pkg;

    localparam int REG_DATA_WIDTH = 32;

    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_NONE
    } lsu_size_e;

    // Unsigned variants exist only for loads; on a store they decode as illegal.
    function automatic lsu_size_e lsu_size(input logic [2:0] funct3, input logic is_store);
        lsu_size_e size;
        case (funct3)
            LSU_B:   size = SZ_BYTE;
            LSU_H:   size = SZ_HALF;
            LSU_W:   size = SZ_WORD;
            LSU_BU:  size = is_store ? SZ_NONE : SZ_BYTE;
            LSU_HU:  size = is_store ? SZ_NONE : SZ_HALF;
            default: size = SZ_NONE;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dmem_ctrl_lsu_align.sv
// Combinational byte-lane logic: legality check, byte enables, store-data
// replication and load-data extraction with sign/zero extension.
module lsu_align
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic [1:0]            i_addr_lo,
    input  logic [2:0]            i_funct3,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_legal,
    output logic [3:0]            o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [DATA_WIDTH-1:0] o_load_data
);

    lsu_size_e             w_size;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    assign w_size    = lsu_size(i_funct3, i_we);
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        o_legal = 1'b0;
        o_be    = 4'b0000;
        o_wdata = '0;
        case (w_size)
            SZ_BYTE: begin
                o_legal = 1'b1;
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_legal = ~i_addr_lo[0];
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SZ_WORD: begin
                o_legal = (i_addr_lo == 2'b00);
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            LSU_B:   o_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            LSU_H:   o_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            LSU_W:   o_load_data = i_rdata;
            LSU_BU:  o_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            LSU_HU:  o_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns MEM-stage load/store requests into req/ack bus
// transactions, stalls the core for their duration and returns extended load data.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_re_i,
    input  logic                  data_we_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [2:0]            funct3_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e                r_state;
    state_e                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_we;
    logic [7:0]            r_tmo_cnt;
    logic                  r_misalign;
    logic                  r_bus_err;
    logic [DATA_WIDTH-1:0] r_load_data;

    logic                  w_req;
    logic                  w_idle;
    logic [1:0]            w_sel_addr_lo;
    logic [2:0]            w_sel_funct3;
    logic                  w_sel_we;
    logic                  w_legal;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata_lane;
    logic [DATA_WIDTH-1:0] w_load_ext;
    logic                  w_timeout;
    logic                  w_bus_fail;

    assign w_req  = data_re_i | data_we_i;
    assign w_idle = (r_state == ST_IDLE);

    // The helper decodes the live request in IDLE and the captured one in BUS.
    assign w_sel_addr_lo = w_idle ? data_addr_i[1:0] : r_addr[1:0];
    assign w_sel_funct3  = w_idle ? funct3_i         : r_funct3;
    assign w_sel_we      = w_idle ? data_we_i        : r_we;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lsu_align (
        .i_addr_lo   (w_sel_addr_lo),
        .i_funct3    (w_sel_funct3),
        .i_we        (w_sel_we),
        .i_wdata     (data_i),
        .i_rdata     (bus_rdata_i),
        .o_legal     (w_legal),
        .o_be        (w_be),
        .o_wdata     (w_wdata_lane),
        .o_load_data (w_load_ext)
    );

    assign w_timeout  = (r_tmo_cnt == TMO_LAST);
    assign w_bus_fail = bus_ack_i ? bus_err_i : w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register
            // samples pre-edge values regardless of process ordering.
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = w_legal ? ST_BUS : ST_DONE;
            ST_BUS:  if (bus_ack_i || w_timeout) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: capture registers are reset too, so bus outputs are defined 0 after reset.
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_we        <= 1'b0;
            r_tmo_cnt   <= '0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tmo_cnt  <= '0;
                    r_bus_err  <= 1'b0;
                    r_misalign <= w_req & ~w_legal;
                    if (w_req && w_legal) begin
                        r_addr   <= data_addr_i;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata_lane;
                        r_funct3 <= funct3_i;
                        r_we     <= data_we_i;
                    end
                end
                ST_BUS: begin
                    if (!bus_ack_i && !w_timeout) r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    r_bus_err <= w_bus_fail;
                    if (bus_ack_i && !bus_err_i && !r_we) r_load_data <= w_load_ext;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_o     = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        case (r_state)
            // Gated by reset so a request held during reset cannot raise stall.
            ST_IDLE: stall_o = w_req & rst;
            ST_BUS: begin
                stall_o     = 1'b1;
                bus_req_o   = 1'b1;
                bus_we_o    = r_we;
                bus_addr_o  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                bus_be_o    = r_be;
                bus_wdata_o = r_wdata;
            end
            ST_DONE: begin
                misalign_o = r_misalign;
                bus_err_o  = r_bus_err;
            end
            default: ;
        endcase
    end

    assign load_data_o = r_load_data;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stores, extended loads, misalignment, bus error,
// timeout and asynchronous reset mid-transaction, with a bus responder in-line.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_re_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_err_i = 1'b0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_re_i   (data_re_i),
        .data_we_i   (data_we_i),
        .data_addr_i (data_addr_i),
        .data_i      (data_i),
        .funct3_i    (funct3_i),
        .stall_o     (stall_o),
        .load_data_o (load_data_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .bus_err_i   (bus_err_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int          obs_stall;
    int          obs_req;
    int          obs_mis;
    int          obs_err;
    int          obs_unstable;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;

    // Issues one request in IDLE and follows it to DONE; ack_at = BUS cycle that
    // receives ack (0 = never). Inputs are scrambled after the first edge.
    task automatic run_access(input logic re, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              input int ack_at, input logic [31:0] rdata, input logic err);
        bit seen_done = 0;
        @(negedge clk);
        data_re_i = re; data_we_i = we; data_addr_i = addr; data_i = wdata; funct3_i = f3;
        obs_stall = 0; obs_req = 0; obs_mis = 0; obs_err = 0; obs_unstable = 0;
        obs_we = 0; obs_addr = '0; obs_be = '0; obs_wdata = '0;
        for (int cyc = 0; cyc < 64 && !seen_done; cyc++) begin
            #1;
            obs_mis += int'(misalign_o);
            obs_err += int'(bus_err_o);
            if (cyc > 0 && !stall_o) begin
                seen_done = 1;
            end else begin
                obs_stall++;
                if (bus_req_o) begin
                    obs_req++;
                    if (obs_req == 1) begin
                        obs_we = bus_we_o; obs_addr = bus_addr_o;
                        obs_be = bus_be_o; obs_wdata = bus_wdata_o;
                    end else if ({bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o} !==
                                 {obs_we, obs_addr, obs_be, obs_wdata}) begin
                        obs_unstable++;
                    end
                    if (obs_req == ack_at) begin
                        bus_ack_i = 1'b1; bus_rdata_i = rdata; bus_err_i = err;
                    end
                end
                @(negedge clk);
                bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h5A5A_5A5A;
                data_re_i = 1'b0; data_we_i = 1'b0;
                data_addr_i = 32'hFFFF_FFFF; data_i = 32'hFFFF_FFFF; funct3_i = 3'd7;
            end
        end
        if (!seen_done) check("done_reached", 32'd0, 32'd1);
    endtask

    initial begin
        #1;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_load", load_data_o, 32'd0);
        check("rst_faults", {30'd0, misalign_o, bus_err_o}, 32'd0);
        check("rst_bus", {bus_req_o, bus_we_o, bus_be_o, 26'd0} | bus_addr_o | bus_wdata_o, 32'd0);
        #20;
        @(negedge clk);
        rst = 1'b1;

        // SW 0x100
        run_access(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, LSU_W, 1, 32'h0, 1'b0);
        check("sw_addr", obs_addr, 32'h100);
        check("sw_be", {28'd0, obs_be}, 32'hF);
        check("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
        check("sw_we", {31'd0, obs_we}, 32'd1);
        check("sw_stall", obs_stall, 32'd2);
        check("sw_req", obs_req, 32'd1);

        run_access(1'b1, 1'b0, 32'h103, 32'h0, LSU_B, 1, 32'h80FF_1234, 1'b0);
        check("lb_data", load_data_o, 32'hFFFF_FF80);
        check("lb_be", {28'd0, obs_be}, 32'h8);
        check("lb_we", {31'd0, obs_we}, 32'd0);

        run_access(1'b1, 1'b0, 32'h103, 32'h0, LSU_BU, 1, 32'h80FF_1234, 1'b0);
        check("lbu_data", load_data_o, 32'h0000_0080);

        run_access(1'b1, 1'b0, 32'h102, 32'h0, LSU_HU, 3, 32'hABCD_0000, 1'b0);
        check("lhu_data", load_data_o, 32'h0000_ABCD);
        check("lhu_stall", obs_stall, 32'd4);
        check("lhu_stable", obs_unstable, 32'd0);

        run_access(1'b0, 1'b1, 32'h101, 32'h1234, LSU_H, 0, 32'h0, 1'b0);
        check("sh_mis_req", obs_req, 32'd0);
        check("sh_mis_pulse", obs_mis, 32'd1);
        check("sh_mis_stall", obs_stall, 32'd1);
        check("sh_mis_err", obs_err, 32'd0);

        run_access(1'b1, 1'b0, 32'h104, 32'h0, LSU_W, 0, 32'h0, 1'b0);
        check("tmo_req", obs_req, TMO);
        check("tmo_err", obs_err, 32'd1);
        check("tmo_load", load_data_o, 32'h0000_ABCD);
        check("tmo_stable", obs_unstable, 32'd0);

        run_access(1'b1, 1'b0, 32'h108, 32'h0, LSU_W, 2, 32'h1111_2222, 1'b1);
        check("berr_err", obs_err, 32'd1);
        check("berr_req", obs_req, 32'd2);
        check("berr_load", load_data_o, 32'h0000_ABCD);

        run_access(1'b0, 1'b1, 32'h102, 32'h0000_00A5, LSU_B, 1, 32'h0, 1'b0);
        check("sb_be", {28'd0, obs_be}, 32'h4);
        check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        check("sb_addr", obs_addr, 32'h100);

        run_access(1'b0, 1'b1, 32'h102, 32'h0000_1234, LSU_H, 1, 32'h0, 1'b0);
        check("sh_be", {28'd0, obs_be}, 32'hC);
        check("sh_wdata", obs_wdata, 32'h1234_1234);

        run_access(1'b1, 1'b0, 32'h102, 32'h0, LSU_H, 1, 32'h8001_0000, 1'b0);
        check("lh_data", load_data_o, 32'hFFFF_8001);

        run_access(1'b0, 1'b1, 32'h100, 32'h0, LSU_BU, 0, 32'h0, 1'b0);
        check("sbu_mis", obs_mis, 32'd1);
        check("sbu_req", obs_req, 32'd0);

        run_access(1'b1, 1'b0, 32'h100, 32'h0, 3'd3, 0, 32'h0, 1'b0);
        check("f3_bad_mis", obs_mis, 32'd1);

        run_access(1'b1, 1'b1, 32'h10C, 32'h1122_3344, LSU_W, 1, 32'h0, 1'b0);
        check("rw_we", {31'd0, obs_we}, 32'd1);
        check("rw_wdata", obs_wdata, 32'h1122_3344);
        check("rw_load", load_data_o, 32'hFFFF_8001);

        // ack while idle is ignored
        @(negedge clk);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        check("idle_ack_stall", {31'd0, stall_o}, 32'd0);
        check("idle_ack_load", load_data_o, 32'hFFFF_8001);
        bus_ack_i = 1'b0;

        // reset asserted in the second BUS cycle
        @(negedge clk);
        data_re_i = 1'b1; data_addr_i = 32'h200; funct3_i = LSU_W;
        @(negedge clk);
        data_re_i = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid_req_before", {31'd0, bus_req_o}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_req", {31'd0, bus_req_o}, 32'd0);
        check("rstmid_stall", {31'd0, stall_o}, 32'd0);
        check("rstmid_addr", bus_addr_o, 32'd0);
        check("rstmid_load", load_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_access(1'b1, 1'b0, 32'h204, 32'h0, LSU_W, 2, 32'h1357_2468, 1'b0);
        check("post_rst_load", load_data_o, 32'h1357_2468);
        check("post_rst_stall", obs_stall, 32'd3);
        check("post_rst_addr", obs_addr, 32'h204);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
